// File: rtl/inst_seq_ctrl.sv
// ---------------------------------------------------------------------------
// inst_seq_ctrl -- instruction sequencer control
//
// Walks an instruction buffer from address 0 up to a latched last address,
// repeating the walk a latched number of passes. It drives the read FIFO head
// counter through rd (advance) and restart (return to 0), and keeps a shadow
// copy of the head address in pc.
//
// Optional feature: define INST_SEQ_PERF_EN to build the stall performance
// counter on stallCnt. With the macro undefined, stallCnt is tied to 0 and no
// counter logic is built.
// ---------------------------------------------------------------------------
module inst_seq_ctrl #(
    parameter int addrLen = 5,
    parameter int iterLen = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [addrLen-1:0] lastAddr,
    input  logic [iterLen-1:0] iterCnt,
    input  logic               stall,
    output logic               rd,
    output logic               restart,
    output logic               instValid,
    output logic [addrLen-1:0] pc,
    output logic [iterLen-1:0] iter,
    output logic               busy,
    output logic               done,
    output logic [31:0]        stallCnt
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        WRAP = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [addrLen-1:0] ADDR_ONE = {{(addrLen-1){1'b0}}, 1'b1};
    localparam logic [iterLen-1:0] ITER_ONE = {{(iterLen-1){1'b0}}, 1'b1};

    state_t             state_q;
    state_t             state_d;
    logic [addrLen-1:0] pc_d;
    logic [iterLen-1:0] iter_d;
    logic [addrLen-1:0] last_addr_q;
    logic [addrLen-1:0] last_addr_d;
    logic [iterLen-1:0] iter_cnt_q;
    logic [iterLen-1:0] iter_cnt_d;

    // A start is only honoured from IDLE; while busy it is ignored.
    logic start_accept;
    assign start_accept = (state_q == IDLE) && start;

    // Abort only acts once a program is in flight; in IDLE it is a no-op.
    logic abort_active;
    assign abort_active = (state_q != IDLE) && abort;

    // The final fetch of a pass: the head is at the last instruction and
    // decode is taking it this cycle.
    logic pass_end;
    assign pass_end = (pc == last_addr_q) && !stall;

    // Final pass when iter has reached iterCnt-1 (iterCnt is non-zero here,
    // a zero count never leaves IDLE for RUN).
    logic last_pass;
    assign last_pass = (iter == (iter_cnt_q - ITER_ONE));

    // Next-state, datapath-next and output decode from the registered state.
    always_comb begin
        // NOTE: every signal written here gets a default before any branch,
        // so no path leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        pc_d        = pc;
        iter_d      = iter;
        last_addr_d = last_addr_q;
        iter_cnt_d  = iter_cnt_q;
        rd          = 1'b0;
        restart     = 1'b0;
        instValid   = 1'b0;
        done        = 1'b0;
        busy        = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (start) begin
                    last_addr_d = lastAddr;
                    iter_cnt_d  = iterCnt;
                    state_d     = (iterCnt == '0) ? DONE : LOAD;
                end
            end

            LOAD: begin
                restart = 1'b1;
                pc_d    = '0;
                iter_d  = '0;
                state_d = RUN;
            end

            RUN: begin
                // stall reaches only rd combinationally; everything else in
                // this branch is held state or a registered next value.
                instValid = 1'b1;
                rd        = !stall;
                if (!stall) begin
                    pc_d = pc + ADDR_ONE;
                end
                if (pass_end) begin
                    state_d = last_pass ? DONE : WRAP;
                end
            end

            WRAP: begin
                // One-cycle bubble per pass while the FIFO head rewinds.
                restart = 1'b1;
                pc_d    = '0;
                iter_d  = iter + ITER_ONE;
                state_d = RUN;
            end

            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort outranks stall and everything the case above decided: the
        // FIFO head rewinds this cycle and the program is dropped silently.
        if (abort_active) begin
            rd        = 1'b0;
            instValid = 1'b0;
            done      = 1'b0;
            restart   = 1'b1;
            pc_d      = '0;
            iter_d    = iter;
            state_d   = IDLE;
        end

        // While reset is held the FIFO head is kept at 0 in lockstep with
        // the sequencer; reset outranks abort.
        if (reset) begin
            rd        = 1'b0;
            instValid = 1'b0;
            done      = 1'b0;
            busy      = 1'b0;
            restart   = 1'b1;
        end
    end

    // State, shadow head address, pass index and latched program bounds.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every register samples the
        // pre-edge values, independent of statement order.
        if (reset) begin
            state_q     <= IDLE;
            pc          <= '0;
            iter        <= '0;
            last_addr_q <= '0;
            iter_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            pc          <= pc_d;
            iter        <= iter_d;
            last_addr_q <= last_addr_d;
            iter_cnt_q  <= iter_cnt_d;
        end
    end

`ifdef INST_SEQ_PERF_EN
    logic [31:0] stall_cnt_q;

    // Saturating count of RUN cycles held off by decode; cleared per program.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (start_accept) begin
            stall_cnt_q <= '0;
        end else if ((state_q == RUN) && stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stallCnt = stall_cnt_q;
`else
    logic unused_start_accept;
    assign unused_start_accept = start_accept;
    assign stallCnt = '0;
`endif

    // The FIFO head can never be advanced and rewound in the same cycle.
    property p_rd_restart_exclusive;
        @(posedge clk) !(rd && restart);
    endproperty
    a_rd_restart_exclusive: assert property (p_rd_restart_exclusive);

    // Completion is a single-cycle pulse.
    property p_done_single;
        @(posedge clk) disable iff (reset) done |=> !done;
    endproperty
    a_done_single: assert property (p_done_single);

endmodule

// File: tb/tb_inst_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_inst_seq_ctrl -- self-checking bench for inst_seq_ctrl
//
// Inputs change on the falling edge and outputs are sampled 1 time unit
// later, well away from the rising edge. A directed vector table covers the
// basic program shapes, hand sequences cover pass counting, abort and reset,
// and a random phase is compared against an event-list model of the program.
// ---------------------------------------------------------------------------
module tb_inst_seq_ctrl;

    localparam int AW = 5;
    localparam int IW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic          stall;
    logic [AW-1:0] last_addr;
    logic [IW-1:0] iter_cnt;
    logic          rd;
    logic          restart;
    logic          inst_valid;
    logic [AW-1:0] pc;
    logic [IW-1:0] iter;
    logic          busy;
    logic          done;
    logic [31:0]   stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    inst_seq_ctrl #(
        .addrLen (AW),
        .iterLen (IW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .lastAddr  (last_addr),
        .iterCnt   (iter_cnt),
        .stall     (stall),
        .rd        (rd),
        .restart   (restart),
        .instValid (inst_valid),
        .pc        (pc),
        .iter      (iter),
        .busy      (busy),
        .done      (done),
        .stallCnt  (stall_cnt)
    );

    // ---------------------------------------------------------------- helpers
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_ctl(input string tag, input logic e_rd, input logic e_rs,
                             input logic e_iv, input logic e_busy, input logic e_done);
        check({tag, " rd"},        32'(rd),         32'(e_rd));
        check({tag, " restart"},   32'(restart),    32'(e_rs));
        check({tag, " instValid"}, 32'(inst_valid), 32'(e_iv));
        check({tag, " busy"},      32'(busy),       32'(e_busy));
        check({tag, " done"},      32'(done),       32'(e_done));
    endtask

    // Apply one cycle of inputs at the falling edge, then settle.
    task automatic drive(input logic r, input logic s, input logic a, input logic st,
                         input logic [AW-1:0] la, input logic [IW-1:0] ic);
        @(negedge clk);
        reset     = r;
        start     = s;
        abort     = a;
        stall     = st;
        last_addr = la;
        iter_cnt  = ic;
        #1;
    endtask

    function automatic logic [31:0] exp_scnt(input int v);
`ifdef INST_SEQ_PERF_EN
        return 32'(v);
`else
        return (v == -1) ? 32'd1 : 32'd0;
`endif
    endfunction

    // ------------------------------------------------------------ vector table
    typedef struct {
        logic          start;
        logic          abort;
        logic          stall;
        logic [AW-1:0] la;
        logic [IW-1:0] ic;
        logic          rd;
        logic          rs;
        logic          iv;
        logic          busy;
        logic          done;
        logic          chk;
        logic [AW-1:0] pc;
        logic [IW-1:0] it;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic a, input logic st,
                                input int la, input int ic,
                                input logic e_rd, input logic e_rs, input logic e_iv,
                                input logic e_busy, input logic e_done,
                                input logic e_chk, input int e_pc, input int e_it);
        vec_t v;
        v.start = s;     v.abort = a;     v.stall = st;
        v.la    = AW'(la);
        v.ic    = IW'(ic);
        v.rd    = e_rd;  v.rs    = e_rs;  v.iv    = e_iv;
        v.busy  = e_busy; v.done = e_done; v.chk  = e_chk;
        v.pc    = AW'(e_pc);
        v.it    = IW'(e_it);
        return v;
    endfunction

    // ------------------------------------------------------ random-phase model
    // A program is a list of events the sequencer must present in order; a
    // stalled fetch stays at the head of the list.
    typedef enum {EV_LOAD, EV_FETCH, EV_WRAP, EV_DONE} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        bit       chk;
        int       pc;
        int       it;
    } ev_t;

    ev_t ev_q[$];
    int  exp_cnt = 0;

    function automatic void plan(input int la, input int ic);
        int after;
        after = (la + 1) % (1 << AW);
        ev_q.delete();
        if (ic == 0) begin
            ev_q.push_back('{EV_DONE, 1'b0, 0, 0});
        end else begin
            ev_q.push_back('{EV_LOAD, 1'b0, 0, 0});
            for (int p = 0; p < ic; p++) begin
                for (int a = 0; a <= la; a++) ev_q.push_back('{EV_FETCH, 1'b1, a, p});
                if (p < ic - 1) ev_q.push_back('{EV_WRAP, 1'b1, after, p});
            end
            ev_q.push_back('{EV_DONE, 1'b1, after, ic - 1});
        end
    endfunction

    // ------------------------------------------------------------------ test
    initial begin
        vec_t vecs[$];
        int   nrd;
        int   nrs;
        int   nd;
        int   fin_iter;
        bit   saw_done;

        reset = 1'b1; start = 1'b0; abort = 1'b0; stall = 1'b0;
        last_addr = '0; iter_cnt = '0;

        // A: lastAddr=3, iterCnt=1, no stall (first row also checks reset state).
        vecs.push_back(mk(1,0,0, 3,1, 0,0,0,0,0, 1,0,0));
        vecs.push_back(mk(0,0,0, 3,1, 0,1,0,1,0, 0,0,0));
        vecs.push_back(mk(0,0,0, 3,1, 1,0,1,1,0, 1,0,0));
        vecs.push_back(mk(0,0,0, 3,1, 1,0,1,1,0, 1,1,0));
        vecs.push_back(mk(0,0,0, 3,1, 1,0,1,1,0, 1,2,0));
        vecs.push_back(mk(0,0,0, 3,1, 1,0,1,1,0, 1,3,0));
        vecs.push_back(mk(0,0,0, 3,1, 0,0,0,1,1, 1,4,0));
        vecs.push_back(mk(0,1,1, 3,1, 0,0,0,0,0, 1,4,0));   // abort/stall in IDLE: no effect
        // C: iterCnt=0 goes straight to a done pulse.
        vecs.push_back(mk(1,0,0, 5,0, 0,0,0,0,0, 1,4,0));
        vecs.push_back(mk(0,0,0, 5,0, 0,0,0,1,1, 1,4,0));
        vecs.push_back(mk(0,0,0, 5,0, 0,0,0,0,0, 1,4,0));
        // D: lastAddr=0, iterCnt=2 -> rd, restart, rd, done.
        vecs.push_back(mk(1,0,0, 0,2, 0,0,0,0,0, 1,4,0));
        vecs.push_back(mk(0,0,0, 0,2, 0,1,0,1,0, 0,0,0));
        vecs.push_back(mk(0,0,0, 0,2, 1,0,1,1,0, 1,0,0));
        vecs.push_back(mk(0,0,0, 0,2, 0,1,0,1,0, 1,1,0));
        vecs.push_back(mk(0,0,0, 0,2, 1,0,1,1,0, 1,0,1));
        vecs.push_back(mk(0,0,0, 0,2, 0,0,0,1,1, 1,1,1));
        vecs.push_back(mk(0,0,0, 0,2, 0,0,0,0,0, 1,1,1));
        // B: lastAddr=3, iterCnt=1, stall on RUN cycles 2-4.
        vecs.push_back(mk(1,0,0, 3,1, 0,0,0,0,0, 1,1,1));
        vecs.push_back(mk(0,0,0, 3,1, 0,1,0,1,0, 0,0,0));
        vecs.push_back(mk(0,0,0, 3,1, 1,0,1,1,0, 1,0,0));
        vecs.push_back(mk(0,0,1, 3,1, 0,0,1,1,0, 1,1,0));
        vecs.push_back(mk(0,0,1, 3,1, 0,0,1,1,0, 1,1,0));
        vecs.push_back(mk(0,0,1, 3,1, 0,0,1,1,0, 1,1,0));
        vecs.push_back(mk(0,0,0, 3,1, 1,0,1,1,0, 1,1,0));
        vecs.push_back(mk(0,0,0, 3,1, 1,0,1,1,0, 1,2,0));
        vecs.push_back(mk(0,0,0, 3,1, 1,0,1,1,0, 1,3,0));
        vecs.push_back(mk(0,0,0, 3,1, 0,0,0,1,1, 1,4,0));
        vecs.push_back(mk(0,0,1, 3,1, 0,0,0,0,0, 1,4,0));   // stall outside RUN is not counted

        // Reset held: FIFO head is told to restart, everything else quiet.
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 0, 0, '0, '0);
            check_ctl($sformatf("reset%0d", i), 0, 1, 0, 0, 0);
        end

        foreach (vecs[i]) begin
            drive(0, vecs[i].start, vecs[i].abort, vecs[i].stall, vecs[i].la, vecs[i].ic);
            check_ctl($sformatf("vec%0d", i), vecs[i].rd, vecs[i].rs, vecs[i].iv,
                      vecs[i].busy, vecs[i].done);
            if (vecs[i].chk) begin
                check($sformatf("vec%0d pc", i),   32'(pc),   32'(vecs[i].pc));
                check($sformatf("vec%0d iter", i), 32'(iter), 32'(vecs[i].it));
            end
        end
        check("stallCnt after 3 stalls", stall_cnt, exp_scnt(3));

        // lastAddr=2, iterCnt=3: 9 reads, load + 2 wrap restarts, one done.
        drive(0, 1, 0, 0, 5'd2, 16'd3);
        nrd = 0; nrs = 0; nd = 0; fin_iter = -1;
        for (int c = 0; c < 40; c++) begin
            drive(0, 0, 0, 0, 5'd2, 16'd3);
            if (rd) nrd++;
            if (restart) nrs++;
            if (done) begin nd++; fin_iter = int'(iter); end
            if (!busy) break;
        end
        check("3-pass rd pulses", 32'(nrd), 32'd9);
        check("3-pass restarts (load+2 wrap)", 32'(nrs), 32'd3);
        check("3-pass done pulses", 32'(nd), 32'd1);
        check("3-pass final iter", 32'(fin_iter), 32'd2);

        // Abort at pc=2 of a 5-instruction program, then a clean rerun.
        drive(0, 1, 0, 0, 5'd4, 16'd1);
        drive(0, 0, 0, 0, 5'd4, 16'd1);
        check_ctl("abort load", 0, 1, 0, 1, 0);
        drive(0, 0, 0, 0, 5'd4, 16'd1);
        drive(0, 0, 0, 0, 5'd4, 16'd1);
        drive(0, 0, 1, 1, 5'd4, 16'd1);
        check("abort at pc", 32'(pc), 32'd2);
        check_ctl("abort cycle", 0, 1, 0, 1, 0);
        saw_done = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive(0, 0, 0, 0, 5'd4, 16'd1);
            if (done) saw_done = 1'b1;
            check($sformatf("after abort%0d busy", c), 32'(busy), 32'd0);
        end
        check("no done after abort", 32'(saw_done), 32'd0);
        drive(0, 1, 0, 0, 5'd4, 16'd1);
        drive(0, 0, 0, 0, 5'd4, 16'd1);
        check_ctl("rerun load", 0, 1, 0, 1, 0);
        drive(0, 0, 0, 0, 5'd4, 16'd1);
        check_ctl("rerun first fetch", 1, 0, 1, 1, 0);
        check("rerun first pc", 32'(pc), 32'd0);
        nd = 0;
        for (int c = 0; c < 20; c++) begin
            drive(0, 0, 0, 0, 5'd4, 16'd1);
            if (done) nd++;
            if (!busy) break;
        end
        check("rerun completes once", 32'(nd), 32'd1);

        // Reset in mid-program, with abort and stall also high.
        drive(0, 1, 0, 0, 5'd6, 16'd2);
        drive(0, 0, 0, 0, 5'd6, 16'd2);
        drive(0, 0, 0, 1, 5'd6, 16'd2);
        drive(0, 0, 0, 0, 5'd6, 16'd2);
        drive(1, 0, 1, 1, 5'd6, 16'd2);
        check_ctl("mid reset", 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 5'd6, 16'd2);
        check_ctl("post reset", 0, 0, 0, 0, 0);
        check("post reset pc", 32'(pc), 32'd0);
        check("post reset iter", 32'(iter), 32'd0);
        check("post reset stallCnt", stall_cnt, 32'd0);

        // Random programs against the event-list model.
        exp_cnt = 0;
        ev_q.delete();
        for (int c = 0; c < 2000; c++) begin
            logic          s;
            logic          a;
            logic          st;
            logic [AW-1:0] la;
            logic [IW-1:0] ic;
            logic          e_rd;
            logic          e_rs;
            logic          e_iv;
            logic          e_busy;
            logic          e_done;
            ev_t           h;
            bit            chk;

            s  = ($urandom_range(0, 3) == 0);
            a  = ($urandom_range(0, 39) == 0);
            st = ($urandom_range(0, 3) == 0);
            la = ($urandom_range(0, 7) == 0) ? AW'(31) : AW'($urandom_range(0, 6));
            ic = IW'($urandom_range(0, 3));
            drive(0, s, a, st, la, ic);

            check($sformatf("rand c%0d stallCnt", c), stall_cnt, exp_scnt(exp_cnt));
            e_rd = 0; e_rs = 0; e_iv = 0; e_busy = 0; e_done = 0; chk = 0;
            h = '{EV_LOAD, 1'b0, 0, 0};
            if (ev_q.size() == 0) begin
                if (s) begin
                    plan(int'(la), int'(ic));
                    exp_cnt = 0;
                end
            end else if (a) begin
                e_rs = 1; e_busy = 1;
                if (ev_q[0].kind == EV_FETCH && st) exp_cnt++;
                ev_q.delete();
            end else begin
                h = ev_q[0];
                chk = h.chk;
                e_busy = 1;
                case (h.kind)
                    EV_LOAD:  begin e_rs = 1; void'(ev_q.pop_front()); end
                    EV_WRAP:  begin e_rs = 1; void'(ev_q.pop_front()); end
                    EV_DONE:  begin e_done = 1; void'(ev_q.pop_front()); end
                    EV_FETCH: begin
                        e_iv = 1;
                        e_rd = !st;
                        if (st) exp_cnt++;
                        else void'(ev_q.pop_front());
                    end
                    default: ;
                endcase
            end
            check_ctl($sformatf("rand c%0d", c), e_rd, e_rs, e_iv, e_busy, e_done);
            if (chk) begin
                check($sformatf("rand c%0d pc", c),   32'(pc),   32'(h.pc));
                check($sformatf("rand c%0d iter", c), 32'(iter), 32'(h.it));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard stop in case something upstream never returns.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog");
    end

endmodule
